// File: rtl/avalon_bus_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_bus_arbiter
//
// Shares one Avalon-MM slave port between two Avalon-MM masters:
//   master 0 - instruction fetch path
//   master 1 - data load/store path (or a later DMA/debug master)
//
// One master is granted at a time. The grant is held for the whole transfer,
// including slave wait states, and the other master is stalled with
// waitrequest. After every completed transfer the arbiter spends one cycle in
// IDLE before it arbitrates again.
//
// Parameters
//   PRIORITY_MODE  0 = round-robin on a tie, 1 = fixed priority (m0 wins)
//
// Ports
//   clk, reset                system clock, asynchronous active-high reset
//   m0_* / m1_*               Avalon-MM slave-side ports facing each master
//   s_*                       Avalon-MM master-side port facing the memory
//   grant[1:0]                registered one-hot grant (bit0=m0, bit1=m1)
// ---------------------------------------------------------------------------
module avalon_bus_arbiter #(
    parameter int PRIORITY_MODE = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,

    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,

    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    // Index of the master that completed the most recent transfer. Starts at 1
    // so that master 0 wins the first round-robin tie after reset.
    logic   last_grant_q, last_grant_d;

    logic req0, req1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic. Arbitration happens only from IDLE, so the grant can
    // never move while a transfer is outstanding.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    if (PRIORITY_MODE != 0) begin
                        state_d = GNT0;
                    end else begin
                        state_d = last_grant_q ? GNT0 : GNT1;
                    end
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!s_waitrequest) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            GNT1: begin
                if (!s_waitrequest) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath steering. Everything is decoded from the state register, so an
    // asynchronous reset immediately parks the slave port and stalls both
    // masters.
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_waitrequest = 1'b1;
        m1_readdata    = '0;
        case (state_q)
            GNT0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
                m0_readdata    = s_readdata;
            end
            GNT1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
                m1_readdata    = s_readdata;
            end
            default: begin
            end
        endcase
    end

    assign grant = {state_q == GNT1, state_q == GNT0};

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for avalon_bus_arbiter. Two instances share all inputs: one in
// round-robin mode (rr_*) and one in fixed-priority mode (fp_*). Read data and
// write attributes are queued when a master issues a request and compared
// when the round-robin instance completes that transfer.
// ---------------------------------------------------------------------------
module tb_avalon_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;

    logic        rr_m0_waitrequest, rr_m1_waitrequest, rr_s_read, rr_s_write;
    logic [31:0] rr_m0_readdata, rr_m1_readdata, rr_s_address, rr_s_writedata;
    logic [3:0]  rr_s_byteenable;
    logic [1:0]  rr_grant;

    logic        fp_m0_waitrequest, fp_m1_waitrequest, fp_s_read, fp_s_write;
    logic [31:0] fp_m0_readdata, fp_m1_readdata, fp_s_address, fp_s_writedata;
    logic [3:0]  fp_s_byteenable;
    logic [1:0]  fp_grant;

    always #5 clk = ~clk;

    // Slave model: zero-latency read data derived from the presented address.
    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return a ^ 32'hDEADBEFF;
    endfunction

    assign s_readdata = slave_rd(rr_s_address);

    avalon_bus_arbiter #(.PRIORITY_MODE(0)) dut_rr (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(rr_m0_waitrequest), .m0_readdata(rr_m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(rr_m1_waitrequest), .m1_readdata(rr_m1_readdata),
        .s_address(rr_s_address), .s_read(rr_s_read), .s_write(rr_s_write),
        .s_writedata(rr_s_writedata), .s_byteenable(rr_s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(rr_grant)
    );

    avalon_bus_arbiter #(.PRIORITY_MODE(1)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(fp_m0_waitrequest), .m0_readdata(fp_m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(fp_m1_waitrequest), .m1_readdata(fp_m1_readdata),
        .s_address(fp_s_address), .s_read(fp_s_read), .s_write(fp_s_write),
        .s_writedata(fp_s_writedata), .s_byteenable(fp_s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(fp_grant)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    logic [31:0] q_rd0[$];
    logic [31:0] q_rd1[$];
    wr_t         q_wr[$];

    // Scoreboard side: pop an expectation on every completed transfer.
    always @(negedge clk) begin
        if (!reset) begin
            if (rr_grant == 2'b01 && m0_read && !rr_m0_waitrequest) begin
                if (q_rd0.size() == 0) check_eq("sb_m0_extra", 32'(q_rd0.size()), 32'd1);
                else check_eq("sb_m0_rdata", rr_m0_readdata, q_rd0.pop_front());
            end
            if (rr_grant == 2'b10 && m1_read && !rr_m1_waitrequest) begin
                if (q_rd1.size() == 0) check_eq("sb_m1_extra", 32'(q_rd1.size()), 32'd1);
                else check_eq("sb_m1_rdata", rr_m1_readdata, q_rd1.pop_front());
            end
            if (rr_grant == 2'b10 && m1_write && !rr_m1_waitrequest) begin
                if (q_wr.size() == 0) begin
                    check_eq("sb_wr_extra", 32'(q_wr.size()), 32'd1);
                end else begin
                    wr_t w;
                    w = q_wr.pop_front();
                    check_eq("sb_wr_addr", rr_s_address, w.a);
                    check_eq("sb_wr_data", rr_s_writedata, w.d);
                    check_eq("sb_wr_be", 32'(rr_s_byteenable), 32'(w.be));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got %0t limit %0d", $time, 100000);
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_grant"}, 32'(rr_grant), 32'd0);
        check_eq({tag, "_sbus"}, 32'({rr_s_read, rr_s_write}), 32'd0);
        check_eq({tag, "_saddr"}, rr_s_address, 32'd0);
        check_eq({tag, "_swdata"}, rr_s_writedata, 32'd0);
        check_eq({tag, "_sbe"}, 32'(rr_s_byteenable), 32'd0);
        check_eq({tag, "_wait"}, 32'({rr_m0_waitrequest, rr_m1_waitrequest}), 32'd3);
        check_eq({tag, "_rd0"}, rr_m0_readdata, 32'd0);
        check_eq({tag, "_rd1"}, rr_m1_readdata, 32'd0);
    endtask

    logic [1:0] rr_seq[7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [1:0] fp_seq[7] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};

    initial begin
        reset = 1'b1;
        m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0;

        // Reset state on both instances.
        sample();
        check_idle("rst");
        check_eq("rst_fp_grant", 32'(fp_grant), 32'd0);
        check_eq("rst_fp_wait", 32'({fp_m0_waitrequest, fp_m1_waitrequest}), 32'd3);
        check_eq("rst_fp_rd", fp_m0_readdata | fp_m1_readdata, 32'd0);
        check_eq("rst_fp_s", fp_s_address | fp_s_writedata | 32'(fp_s_byteenable)
                 | 32'({fp_s_read, fp_s_write}), 32'd0);

        // No requests for 10 cycles.
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            check_idle("idle");
            next_cycle();
        end

        // Single m0 read, zero-wait slave.
        m0_read = 1'b1; m0_address = 32'h10; m0_byteenable = 4'hF;
        q_rd0.push_back(slave_rd(32'h10));
        sample();
        check_eq("rd_c1_grant", 32'(rr_grant), 32'd0);
        check_eq("rd_c1_wait", 32'(rr_m0_waitrequest), 32'd1);
        next_cycle();
        sample();
        check_eq("rd_c2_grant", 32'(rr_grant), 32'd1);
        check_eq("rd_c2_sread", 32'(rr_s_read), 32'd1);
        check_eq("rd_c2_saddr", rr_s_address, 32'h10);
        check_eq("rd_c2_rdata", rr_m0_readdata, 32'hDEADBEEF);
        check_eq("rd_c2_wait", 32'(rr_m0_waitrequest), 32'd0);
        next_cycle();
        m0_read = 1'b0;
        sample();
        check_eq("rd_c3_grant", 32'(rr_grant), 32'd0);

        // Stretched m1 write, m0 raises a read while it is in progress.
        next_cycle();
        m1_write = 1'b1; m1_address = 32'h1004; m1_writedata = 32'h12345678;
        m1_byteenable = 4'b0011; s_waitrequest = 1'b1;
        q_wr.push_back('{a: 32'h1004, d: 32'h12345678, be: 4'b0011});
        sample();
        check_eq("wr_arb_grant", 32'(rr_grant), 32'd0);
        check_eq("wr_arb_wait", 32'(rr_m1_waitrequest), 32'd1);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if (k == 1) begin
                m0_read = 1'b1; m0_address = 32'h20;
                q_rd0.push_back(slave_rd(32'h20));
            end
            if (k == 3) s_waitrequest = 1'b0;
            sample();
            check_eq("wr_grant", 32'(rr_grant), 32'd2);
            check_eq("wr_swrite", 32'(rr_s_write), 32'd1);
            check_eq("wr_saddr", rr_s_address, 32'h1004);
            check_eq("wr_sdata", rr_s_writedata, 32'h12345678);
            check_eq("wr_sbe", 32'(rr_s_byteenable), 32'd3);
            check_eq("wr_m1_wait", 32'(rr_m1_waitrequest), (k < 3) ? 32'd1 : 32'd0);
            check_eq("wr_m0_stall", 32'(rr_m0_waitrequest), 32'd1);
        end
        next_cycle();
        m1_write = 1'b0;
        sample();
        check_eq("wr_idle_grant", 32'(rr_grant), 32'd0);
        check_eq("wr_idle_m0wait", 32'(rr_m0_waitrequest), 32'd1);
        next_cycle();
        sample();
        check_eq("wr_m0_grant", 32'(rr_grant), 32'd1);
        check_eq("wr_m0_wait", 32'(rr_m0_waitrequest), 32'd0);
        next_cycle();
        m0_read = 1'b0;
        sample();
        check_eq("wr_end_grant", 32'(rr_grant), 32'd0);

        // Reset in the middle of a stalled m1 write.
        next_cycle();
        m1_write = 1'b1; m1_address = 32'h2000; m1_writedata = 32'hCAFEF00D;
        m1_byteenable = 4'hF; s_waitrequest = 1'b1;
        sample();
        check_eq("rm_arb_grant", 32'(rr_grant), 32'd0);
        next_cycle();
        sample();
        check_eq("rm_pre_grant", 32'(rr_grant), 32'd2);
        check_eq("rm_pre_swrite", 32'(rr_s_write), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rm_async_swrite", 32'(rr_s_write), 32'd0);
        check_eq("rm_async_grant", 32'(rr_grant), 32'd0);
        check_eq("rm_async_m1wait", 32'(rr_m1_waitrequest), 32'd1);
        check_eq("rm_async_saddr", rr_s_address, 32'd0);
        check_eq("rm_async_fpgrant", 32'(fp_grant), 32'd0);

        // Both masters request continuously from reset release.
        m1_write = 1'b0; m1_read = 1'b1; m1_address = 32'h200;
        m0_read = 1'b1; m0_address = 32'h100; s_waitrequest = 1'b0;
        q_rd0.push_back(slave_rd(32'h100)); q_rd0.push_back(slave_rd(32'h100));
        q_rd1.push_back(slave_rd(32'h200)); q_rd1.push_back(slave_rd(32'h200));
        next_cycle();
        reset = 1'b0;
        sample();
        check_eq("tie_rel_grant", 32'(rr_grant), 32'd0);
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            sample();
            check_eq("rr_grant_seq", 32'(rr_grant), 32'(rr_seq[i]));
            check_eq("fp_grant_seq", 32'(fp_grant), 32'(fp_seq[i]));
            check_eq("fp_m1_starved", 32'(fp_m1_waitrequest), 32'd1);
        end

        // m0 drops out; fixed-priority arbiter finally serves m1.
        next_cycle();
        m0_read = 1'b0;
        q_rd1.push_back(slave_rd(32'h200));
        sample();
        check_eq("drop_idle_rr", 32'(rr_grant), 32'd0);
        check_eq("drop_idle_fp", 32'(fp_grant), 32'd0);
        next_cycle();
        sample();
        check_eq("drop_gnt_rr", 32'(rr_grant), 32'd2);
        check_eq("drop_gnt_fp", 32'(fp_grant), 32'd2);
        check_eq("drop_fp_m1wait", 32'(fp_m1_waitrequest), 32'd0);
        next_cycle();
        m1_read = 1'b0;
        sample();
        check_eq("end_grant_rr", 32'(rr_grant), 32'd0);
        check_eq("end_grant_fp", 32'(fp_grant), 32'd0);

        next_cycle();
        check_eq("sb_rd0_left", 32'(q_rd0.size()), 32'd0);
        check_eq("sb_rd1_left", 32'(q_rd1.size()), 32'd0);
        check_eq("sb_wr_left", 32'(q_wr.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
